lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
Parametrised, handshaked load/store unit for the MEM stage of the RISC-V core. It replaces the purely combinational memory stage with a registered FSM that does four things:
- generates aligned addresses, byte strobes and lane-shifted write data;
- waits a variable number of cycles for data-memory responses;
- extracts and sign/zero-extends load data by byte offset;
- flags misaligned accesses and bus timeouts.
It sits between EX (upstream valid/ready) and WB (downstream valid/ready).

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. At 64, ld/sd/lwu are enabled.
TIMEOUT, 64, maximum cycles in WAIT before a bus error is flagged; must be at least 2.
STRB_W, XLEN/8, byte lanes (derived; never overridden).
OFF_W, log2(STRB_W), byte-offset bits (derived).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX presents an instruction
in_ready  out  1  stage accepts the instruction
in_opcode  in  7  instruction opcode
in_funct3  in  3  width/sign selector
in_rd  in  5  destination register
in_alu_out  in  XLEN  effective address, or ALU result for non-memory ops
in_rs2_data  in  XLEN  store data
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts the request
mem_addr  out  XLEN  request address with the low OFF_W bits forced to 0
mem_we  out  1  1 for a store
mem_wstrb  out  STRB_W  byte-lane enables
mem_wdata  out  XLEN  lane-shifted store data
mem_rsp_valid  in  1  response/ack; also required for stores
mem_rdata  in  XLEN  read data
out_valid  out  1  result valid to WB
out_ready  in  1  WB accepts the result
out_data  out  XLEN  extended load data for loads; in_alu_out otherwise
out_rd  out  5  registered rd
out_opcode  out  7  registered opcode
out_funct3  out  3  registered funct3
out_misaligned  out  1  misaligned-access exception
out_bus_err  out  1  timeout exception
out_fault_addr  out  XLEN  unaligned address when an exception is flagged, else 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; timeout counter=0.
  - Every out_* signal, mem_req_valid, mem_we, mem_wstrb, mem_addr and mem_wdata = 0.
  - Reset asserted mid-transaction abandons the transaction; no output is produced for it.
- FSM states: IDLE, REQ, WAIT, DONE.
- in_ready = (state==IDLE). The instruction and all its fields are captured on an in_valid&&in_ready edge.
- IDLE → DONE on capture when any of the following holds; latency is 1 cycle:
  - a non-memory opcode (pass-through, out_data=alu_out);
  - a misaligned memory op (out_misaligned=1, no memory request);
  - an illegal funct3 (011 or 110 when XLEN=32; 111 always): treated as misaligned.
- IDLE → REQ on capture of an aligned load or store.
- REQ:
  - mem_req_valid=1 with address, we, strb and wdata held stable.
  - Leave on mem_req_valid&&mem_req_ready, going to WAIT with counter=0.
- WAIT:
  - Counter increments each cycle.
  - mem_rsp_valid → DONE. For a load, out_data is the extended rdata.
  - If the counter reaches TIMEOUT-1 with no response → DONE with out_bus_err=1 and out_data=0.
  - A response arriving in the same cycle as the timeout wins (no error).
- mem_rsp_valid outside WAIT is ignored, so late responses are dropped.
- DONE: out_valid=1 with all out_* held; out_ready → IDLE. The next instruction cannot be accepted in that same cycle, so minimum throughput is one instruction per 2 cycles.
- Alignment rules, with off = alu_out[OFF_W-1:0]:
  - byte ops: always aligned;
  - half ops: off[0]==0;
  - word ops: off[1:0]==0;
  - double ops: off==0.
- Store data:
  - mem_wstrb = size mask (1, 3, 0xF or 0xFF) << off.
  - mem_wdata = rs2_data << (8*off). Lanes outside the strobe are don't-care but are driven as the shifted value.
- Load data: shifted = mem_rdata >> (8*off). Then:
  - lb/lh/lw: sign-extend from bit 7/15/31;
  - lbu/lhu/lwu: zero-extend;
  - ld: pass through.
- Store opcode: out_data = alu_out and out_rd is passed through unchanged; WB ignores it by opcode.

Decomposition:
- Opcode and funct3 constants (opcode_I_ld, opcode_S, funct3_lb…funct3_sw, plus new funct3_ld/sd/lwu) go in the shared define header.
- The FSM state encoding is a localparam inside the module.
- One combinational sub-module, lsu_align: size/offset → strb, wdata shift, misaligned flag, load extraction/extension. It is shared with a future instruction-side unit.

Test Plan:
1. XLEN=32. sw alu_out=0x1000, rs2=0xDEADBEEF, mem_req_ready=1, rsp after 3 cycles → mem_addr=0x1000, wstrb=0xF, wdata=0xDEADBEEF, we=1; out_valid 5 cycles after capture; out_misaligned=0.
2. lb alu_out=0x2003, mem_rdata=0x80FF_1234 → wstrb=0x8; out_data=0xFFFF_FF80. lbu with the same inputs → out_data=0x0000_0080.
3. lh alu_out=0x3001 → no mem_req_valid; out_valid next cycle; out_misaligned=1; out_fault_addr=0x3001.
4. lw, rsp never arrives, TIMEOUT=8 → out_bus_err=1 exactly 8 cycles after entering WAIT. A response injected one cycle later is ignored, and the next op completes normally.
5. Backpressure: out_ready=0 for 4 cycles in DONE → outputs held stable and in_ready=0. mem_req_ready low for 3 cycles → request fields stable throughout.
6. rst_n pulsed low during WAIT → all outputs 0 immediately, state IDLE. XLEN=64 sd at off=0 → wstrb=0xFF.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// rtl/lsu_mem_stage_pkg.sv - opcode/funct3 constants and lane helpers shared by the load/store unit
package lsu_mem_stage_pkg;

  localparam logic [6:0] opcode_i_ld = 7'b0000011;
  localparam logic [6:0] opcode_s    = 7'b0100011;

  localparam logic [2:0] funct3_lb  = 3'b000;
  localparam logic [2:0] funct3_lh  = 3'b001;
  localparam logic [2:0] funct3_lw  = 3'b010;
  localparam logic [2:0] funct3_ld  = 3'b011;
  localparam logic [2:0] funct3_lbu = 3'b100;
  localparam logic [2:0] funct3_lhu = 3'b101;
  localparam logic [2:0] funct3_lwu = 3'b110;
  localparam logic [2:0] funct3_sb  = 3'b000;
  localparam logic [2:0] funct3_sh  = 3'b001;
  localparam logic [2:0] funct3_sw  = 3'b010;
  localparam logic [2:0] funct3_sd  = 3'b011;

  // Byte-lane enable pattern for an access of 1, 2, 4 or 8 bytes at offset 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - size/offset decode: strobes, store lane shift, misalignment, load extraction
module lsu_align
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int STRB_W = XLEN / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [2:0]        funct3,
  input  logic              is_store,
  input  logic [OFF_W-1:0]  off,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   load_data,
  output logic [STRB_W-1:0] strb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              misaligned
);

  logic [1:0]      size;
  logic [OFF_W-1:0] align_mask;
  logic            illegal;
  logic [XLEN-1:0] shifted;

  assign size       = funct3[1:0];
  assign align_mask = OFF_W'((4'd1 << size) - 4'd1);

  // Stores have no unsigned variants; 64-bit widths only exist on RV64.
  always_comb begin
    illegal = (funct3 == 3'b111) || (is_store && funct3[2]);
    if (XLEN == 32 && (funct3 == funct3_ld || funct3 == funct3_lwu)) begin
      illegal = 1'b1;
    end
  end

  assign misaligned = illegal || (|(off & align_mask));
  assign strb       = STRB_W'(size_mask(size)) << off;
  assign wdata      = store_data << {off, 3'b000};
  assign shifted    = load_data >> {off, 3'b000};

  always_comb begin
    case (funct3)
      funct3_lb:  rdata_ext = XLEN'($signed(shifted[7:0]));
      funct3_lh:  rdata_ext = XLEN'($signed(shifted[15:0]));
      funct3_lw:  rdata_ext = XLEN'($signed(shifted[31:0]));
      funct3_lbu: rdata_ext = XLEN'(shifted[7:0]);
      funct3_lhu: rdata_ext = XLEN'(shifted[15:0]);
      funct3_lwu: rdata_ext = XLEN'(shifted[31:0]);
      default:    rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - handshaked MEM-stage load/store unit with misalignment and timeout detection
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  localparam int STRB_W = XLEN / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_rs2_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [4:0]        out_rd,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic              out_misaligned,
  output logic              out_bus_err,
  output logic [XLEN-1:0]   out_fault_addr
);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_req  = 2'd1;
  localparam logic [1:0] st_wait = 2'd2;
  localparam logic [1:0] st_done = 2'd3;
  localparam int cnt_w = $clog2(TIMEOUT);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [cnt_w-1:0]  cnt;
  logic [XLEN-1:0]   alu_q;
  logic              is_load_q;
  logic              in_is_load;
  logic              in_is_store;
  logic              in_is_mem;
  logic              fire;
  logic              timeout_hit;

  logic [2:0]        al_funct3;
  logic [OFF_W-1:0]  al_off;
  logic [STRB_W-1:0] al_strb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata_ext;
  logic              al_misaligned;

  assign in_is_load  = (in_opcode == opcode_i_ld);
  assign in_is_store = (in_opcode == opcode_s);
  assign in_is_mem   = in_is_load || in_is_store;
  assign fire        = in_valid && in_ready;
  assign timeout_hit = (cnt == cnt_w'(TIMEOUT - 1));

  // One aligner serves both directions: incoming fields while idle, captured fields afterwards.
  assign al_funct3 = in_ready ? in_funct3 : out_funct3;
  assign al_off    = in_ready ? in_alu_out[OFF_W-1:0] : alu_q[OFF_W-1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_funct3),
    .is_store   (in_is_store),
    .off        (al_off),
    .store_data (in_rs2_data),
    .load_data  (mem_rdata),
    .strb       (al_strb),
    .wdata      (al_wdata),
    .rdata_ext  (al_rdata_ext),
    .misaligned (al_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= st_idle;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle: begin
        if (in_valid) begin
          state_nxt = (in_is_mem && !al_misaligned) ? st_req : st_done;
        end
      end
      st_req:  if (mem_req_ready) state_nxt = st_wait;
      st_wait: if (mem_rsp_valid || timeout_hit) state_nxt = st_done;
      default: if (out_ready) state_nxt = st_idle;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state)
      st_idle: in_ready      = 1'b1;
      st_req:  mem_req_valid = 1'b1;
      st_done: out_valid     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      alu_q          <= '0;
      is_load_q      <= 1'b0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wstrb      <= '0;
      mem_wdata      <= '0;
      out_data       <= '0;
      out_rd         <= '0;
      out_opcode     <= '0;
      out_funct3     <= '0;
      out_misaligned <= 1'b0;
      out_bus_err    <= 1'b0;
      out_fault_addr <= '0;
    end else begin
      case (state)
        st_idle: begin
          cnt <= '0;
          if (fire) begin
            alu_q          <= in_alu_out;
            is_load_q      <= in_is_load;
            out_rd         <= in_rd;
            out_opcode     <= in_opcode;
            out_funct3     <= in_funct3;
            out_bus_err    <= 1'b0;
            out_misaligned <= 1'b0;
            out_fault_addr <= '0;
            if (!in_is_mem) begin
              out_data <= in_alu_out;
            end else if (al_misaligned) begin
              out_data       <= '0;
              out_misaligned <= 1'b1;
              out_fault_addr <= in_alu_out;
            end else begin
              mem_addr  <= {in_alu_out[XLEN-1:OFF_W], {OFF_W{1'b0}}};
              mem_we    <= in_is_store;
              mem_wstrb <= al_strb;
              mem_wdata <= al_wdata;
            end
          end
        end
        st_req: cnt <= '0;
        st_wait: begin
          // A response coincident with the last allowed cycle is still honoured.
          if (mem_rsp_valid) begin
            out_data <= is_load_q ? al_rdata_ext : alu_q;
          end else if (timeout_hit) begin
            out_data       <= '0;
            out_bus_err    <= 1'b1;
            out_fault_addr <= alu_q;
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage (RV32 and RV64 instances)
module tb_lsu_mem_stage;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          stall;
    int          delay;
    int          hold;
    bit          inject;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    int          e_lat;
    bit          e_chk_data;
    logic [31:0] e_data;
    bit          e_mis;
    bit          e_err;
    logic [31:0] e_fault;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_alu_out = '0;
  logic [31:0] in_rs2_data = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_misaligned;
  logic        out_bus_err;
  logic [31:0] out_fault_addr;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [6:0]  w_in_opcode = '0;
  logic [2:0]  w_in_funct3 = '0;
  logic [4:0]  w_in_rd = '0;
  logic [63:0] w_in_alu_out = '0;
  logic [63:0] w_in_rs2_data = '0;
  logic        w_mem_req_valid;
  logic        w_mem_req_ready = 1'b0;
  logic [63:0] w_mem_addr;
  logic        w_mem_we;
  logic [7:0]  w_mem_wstrb;
  logic [63:0] w_mem_wdata;
  logic        w_mem_rsp_valid = 1'b0;
  logic [63:0] w_mem_rdata = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_rd;
  logic [6:0]  w_out_opcode;
  logic [2:0]  w_out_funct3;
  logic        w_out_misaligned;
  logic        w_out_bus_err;
  logic [63:0] w_out_fault_addr;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_alu_out(in_alu_out), .in_rs2_data(in_rs2_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_misaligned(out_misaligned),
    .out_bus_err(out_bus_err), .out_fault_addr(out_fault_addr)
  );

  lsu_mem_stage #(.XLEN(64), .TIMEOUT(TIMEOUT)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_opcode(w_in_opcode), .in_funct3(w_in_funct3),
    .in_rd(w_in_rd), .in_alu_out(w_in_alu_out), .in_rs2_data(w_in_rs2_data),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready), .mem_addr(w_mem_addr),
    .mem_we(w_mem_we), .mem_wstrb(w_mem_wstrb), .mem_wdata(w_mem_wdata),
    .mem_rsp_valid(w_mem_rsp_valid), .mem_rdata(w_mem_rdata),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_rd(w_out_rd),
    .out_opcode(w_out_opcode), .out_funct3(w_out_funct3), .out_misaligned(w_out_misaligned),
    .out_bus_err(w_out_bus_err), .out_fault_addr(w_out_fault_addr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] opcode, input logic [2:0] funct3, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rdata,
                              input int stall, input int delay, input int hold,
                              input bit e_req, input logic [31:0] e_addr, input bit e_we,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata, input int e_lat,
                              input bit e_chk_data, input logic [31:0] e_data, input bit e_mis,
                              input bit e_err, input logic [31:0] e_fault);
    vec_t v;
    v.opcode = opcode; v.funct3 = funct3; v.rd = rd; v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
    v.stall = stall; v.delay = delay; v.hold = hold; v.inject = 1'b0;
    v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_strb = e_strb; v.e_wdata = e_wdata;
    v.e_lat = e_lat; v.e_chk_data = e_chk_data; v.e_data = e_data; v.e_mis = e_mis;
    v.e_err = e_err; v.e_fault = e_fault;
    return v;
  endfunction

  // Reference: byte arithmetic on the access size and offset.
  function automatic vec_t model(input vec_t v);
    bit     ld, st, illegal, timed_out;
    int     sz, off;
    longint mask, val;
    ld  = (v.opcode == 7'h03);
    st  = (v.opcode == 7'h23);
    sz  = 1 << v.funct3[1:0];
    off = int'(v.alu % 4);
    illegal   = (v.funct3 == 3) || (v.funct3 >= 6) || (st && v.funct3 >= 4);
    v.e_mis   = (ld || st) && (illegal || (off % sz) != 0);
    v.e_req   = (ld || st) && !v.e_mis;
    v.e_addr  = v.alu - 32'(off);
    v.e_we    = st;
    v.e_strb  = 4'(((1 << sz) - 1) << off);
    v.e_wdata = 32'(longint'(v.rs2) << (8 * off));
    timed_out = v.delay > TIMEOUT - 1;
    v.e_lat   = v.e_req ? v.stall + (timed_out ? TIMEOUT - 1 : v.delay) + 3 : 1;
    v.e_err   = v.e_req && timed_out;
    v.e_chk_data = !v.e_mis;
    mask = (longint'(1) << (8 * sz)) - 1;
    val  = (longint'(v.rdata) >> (8 * off)) & mask;
    if (ld && !v.funct3[2] && val[8*sz-1]) val = val | ~mask;
    if (!(ld || st))  v.e_data = v.alu;
    else if (v.e_err) v.e_data = 32'h0;
    else if (ld)      v.e_data = 32'(val);
    else              v.e_data = v.alu;
    v.e_fault = (v.e_mis || v.e_err) ? v.alu : 32'h0;
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int cyc;
    bit done;
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_opcode = v.opcode; in_funct3 = v.funct3; in_rd = v.rd;
    in_alu_out = v.alu; in_rs2_data = v.rs2;
    @(negedge clk);
    in_valid = 1'b0; in_alu_out = $urandom; in_rs2_data = $urandom; in_rd = 5'($urandom);
    cyc  = 1;
    done = out_valid;
    chk("req_valid", mem_req_valid, v.e_req);
    if (v.e_req) begin
      chk("req_addr", mem_addr, v.e_addr);
      chk("req_we", mem_we, v.e_we);
      chk("req_strb", mem_wstrb, v.e_strb);
      chk("req_wdata", mem_wdata, v.e_wdata);
      for (int i = 0; i < v.stall; i++) begin
        @(negedge clk);
        cyc++;
        chk("stall_valid", mem_req_valid, 1);
        chk("stall_addr", mem_addr, v.e_addr);
        chk("stall_strb", mem_wstrb, v.e_strb);
        chk("stall_wdata", mem_wdata, v.e_wdata);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      cyc++;
      chk("req_dropped", mem_req_valid, 0);
      for (int k = 0; k < TIMEOUT + 2 && !done; k++) begin
        mem_rsp_valid = (k == v.delay);
        mem_rdata     = (k == v.delay) ? v.rdata : $urandom;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        cyc++;
        done = out_valid;
      end
    end
    chk("out_valid", out_valid, 1);
    chk("latency", cyc, v.e_lat);
    if (v.e_chk_data) chk("out_data", out_data, v.e_data);
    chk("out_rd", out_rd, v.rd);
    chk("out_opcode", out_opcode, v.opcode);
    chk("out_funct3", out_funct3, v.funct3);
    chk("out_misaligned", out_misaligned, v.e_mis);
    chk("out_bus_err", out_bus_err, v.e_err);
    chk("out_fault_addr", out_fault_addr, v.e_fault);
    for (int i = 0; i < v.hold; i++) begin
      if (v.inject && i == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_bus_err", out_bus_err, v.e_err);
      if (v.e_chk_data) chk("hold_data", out_data, v.e_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("released", out_valid, 0);
  endtask

  task automatic run64(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] alu,
                       input logic [63:0] rs2, input logic [63:0] rdata, input logic [7:0] e_strb,
                       input logic [63:0] e_wdata, input logic [63:0] e_data);
    w_in_valid = 1'b1; w_in_opcode = opc; w_in_funct3 = f3; w_in_rd = 5'd20;
    w_in_alu_out = alu; w_in_rs2_data = rs2;
    @(negedge clk);
    w_in_valid = 1'b0;
    chk("x64_req_valid", w_mem_req_valid, 1);
    chk("x64_addr", w_mem_addr, alu & ~64'h7);
    chk("x64_strb", w_mem_wstrb, e_strb);
    chk("x64_wdata", w_mem_wdata, e_wdata);
    w_mem_req_ready = 1'b1;
    @(negedge clk);
    w_mem_req_ready = 1'b0;
    w_mem_rsp_valid = 1'b1; w_mem_rdata = rdata;
    @(negedge clk);
    w_mem_rsp_valid = 1'b0;
    chk("x64_out_valid", w_out_valid, 1);
    chk("x64_out_data", w_out_data, e_data);
    chk("x64_misaligned", w_out_misaligned, 0);
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_opcode", out_opcode, 0);
    chk("rst_out_funct3", out_funct3, 0);
    chk("rst_misaligned", out_misaligned, 0);
    chk("rst_bus_err", out_bus_err, 0);
    chk("rst_fault", out_fault_addr, 0);
    chk("rst64_strb", w_mem_wstrb, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    tbl.push_back(mk(7'h23, 3'd2, 5'd1, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 2, 0,
                     1, 32'h1000, 1, 4'hF, 32'hDEADBEEF, 5, 1, 32'h1000, 0, 0, 32'h0));
    tbl.push_back(mk(7'h03, 3'd0, 5'd2, 32'h2003, 32'h0, 32'h80FF1234, 0, 1, 0,
                     1, 32'h2000, 0, 4'h8, 32'h0, 4, 1, 32'hFFFFFF80, 0, 0, 32'h0));
    tbl.push_back(mk(7'h03, 3'd4, 5'd3, 32'h2003, 32'h0, 32'h80FF1234, 0, 1, 0,
                     1, 32'h2000, 0, 4'h8, 32'h0, 4, 1, 32'h00000080, 0, 0, 32'h0));
    tbl.push_back(mk(7'h03, 3'd1, 5'd4, 32'h3001, 32'h0, 32'h0, 0, 0, 0,
                     0, 32'h0, 0, 4'h0, 32'h0, 1, 0, 32'h0, 1, 0, 32'h3001));
    v = mk(7'h03, 3'd2, 5'd5, 32'h4000, 32'h0, 32'h0, 0, 99, 2,
           1, 32'h4000, 0, 4'hF, 32'h0, 10, 1, 32'h0, 0, 1, 32'h4000);
    v.inject = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk(7'h03, 3'd2, 5'd6, 32'h5004, 32'h0, 32'h12345678, 0, 0, 0,
                     1, 32'h5004, 0, 4'hF, 32'h0, 3, 1, 32'h12345678, 0, 0, 32'h0));
    tbl.push_back(mk(7'h23, 3'd1, 5'd7, 32'h6002, 32'h0000ABCD, 32'h0, 3, 2, 4,
                     1, 32'h6000, 1, 4'hC, 32'hABCD0000, 8, 1, 32'h6002, 0, 0, 32'h0));
    tbl.push_back(mk(7'h33, 3'd0, 5'd8, 32'h12345678, 32'h0, 32'h0, 0, 0, 0,
                     0, 32'h0, 0, 4'h0, 32'h0, 1, 1, 32'h12345678, 0, 0, 32'h0));
    tbl.push_back(mk(7'h03, 3'd3, 5'd9, 32'h7000, 32'h0, 32'h0, 0, 0, 0,
                     0, 32'h0, 0, 4'h0, 32'h0, 1, 0, 32'h0, 1, 0, 32'h7000));
    tbl.push_back(mk(7'h03, 3'd5, 5'd10, 32'h8002, 32'h0, 32'h80010000, 0, 1, 0,
                     1, 32'h8000, 0, 4'hC, 32'h0, 4, 1, 32'h00008001, 0, 0, 32'h0));
    tbl.push_back(mk(7'h03, 3'd1, 5'd11, 32'h8002, 32'h0, 32'h80010000, 0, 1, 0,
                     1, 32'h8000, 0, 4'hC, 32'h0, 4, 1, 32'hFFFF8001, 0, 0, 32'h0));
    tbl.push_back(mk(7'h03, 3'd2, 5'd12, 32'h9000, 32'h0, 32'hCAFEF00D, 0, 7, 0,
                     1, 32'h9000, 0, 4'hF, 32'h0, 10, 1, 32'hCAFEF00D, 0, 0, 32'h0));
    tbl.push_back(mk(7'h23, 3'd0, 5'd13, 32'hA001, 32'h00000055, 32'h0, 0, 0, 1,
                     1, 32'hA000, 1, 4'h2, 32'h00005500, 3, 1, 32'hA001, 0, 0, 32'h0));
    tbl.push_back(mk(7'h23, 3'd2, 5'd14, 32'hB000, 32'h00000001, 32'h0, 1, 99, 0,
                     1, 32'hB000, 1, 4'hF, 32'h00000001, 11, 1, 32'h0, 0, 1, 32'hB000));
    tbl.push_back(mk(7'h23, 3'd2, 5'd15, 32'hC002, 32'h1, 32'h0, 0, 0, 0,
                     0, 32'h0, 0, 4'h0, 32'h0, 1, 0, 32'h0, 1, 0, 32'hC002));

    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_op(tbl[i]);

    for (int n = 0; n < 40; n++) begin
      vec_t r;
      case ($urandom_range(0, 4))
        0, 1:    r.opcode = 7'h03;
        2, 3:    r.opcode = 7'h23;
        default: r.opcode = 7'h13;
      endcase
      r.funct3 = (r.opcode == 7'h23) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      r.rd     = 5'($urandom);
      r.alu    = $urandom;
      r.rs2    = $urandom;
      r.rdata  = $urandom;
      r.stall  = $urandom_range(0, 2);
      r.delay  = $urandom_range(0, 9);
      r.hold   = $urandom_range(0, 2);
      r.inject = 1'($urandom_range(0, 1));
      run_op(model(r));
    end

    // Reset in the middle of a pending load abandons it.
    in_valid = 1'b1; in_opcode = 7'h03; in_funct3 = 3'd2; in_rd = 5'd13; in_alu_out = 32'hD000;
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("post_rst_no_out", out_valid, 0);
    @(negedge clk);
    chk("post_rst_no_out2", out_valid, 0);
    run_op(tbl[5]);

    run64(7'h23, 3'd3, 64'h1000, 64'h0123456789ABCDEF, 64'h0, 8'hFF, 64'h0123456789ABCDEF, 64'h1000);
    run64(7'h03, 3'd3, 64'h2008, 64'h0, 64'hFEDCBA9876543210, 8'hFF, 64'h0, 64'hFEDCBA9876543210);
    run64(7'h03, 3'd6, 64'h3004, 64'h0, 64'h89ABCDEF01234567, 8'hF0, 64'h0, 64'h0000000089ABCDEF);
    run64(7'h03, 3'd2, 64'h3004, 64'h0, 64'h89ABCDEF01234567, 8'hF0, 64'h0, 64'hFFFFFFFF89ABCDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
